// File: rtl/vga_timing_decoder_if.sv
// ---------------------------------------------------------------------------
// vga_timing_decoder_if
// Groups the video pins seen by the timing decoder together with everything
// the decoder recovers from them.
//   i_hs, i_vs    sync pins, active low
//   i_rgb         single-bit colour pin
//   o_x, o_y      recovered pixel coordinates (0 outside the visible area)
//   o_active      o_x/o_y/o_pixel describe a visible pixel (locked only)
//   o_pixel       sampled colour for (o_x,o_y)
//   o_frame_start one-cycle pulse on pixel (0,0)
//   o_locked      timing has matched the parameters for enough frames
//   o_h_err       one-cycle pulse: bad line length or HSYNC width
//   o_v_err       one-cycle pulse: bad frame length or VSYNC width
// master : the side that produces the pins and observes the results
// slave  : the decoder itself
// ---------------------------------------------------------------------------
interface vga_timing_decoder_if;
   logic       i_hs;
   logic       i_vs;
   logic       i_rgb;
   logic [9:0] o_x;
   logic [9:0] o_y;
   logic       o_active;
   logic       o_pixel;
   logic       o_frame_start;
   logic       o_locked;
   logic       o_h_err;
   logic       o_v_err;

   modport master (
      output i_hs, i_vs, i_rgb,
      input  o_x, o_y, o_active, o_pixel, o_frame_start,
      input  o_locked, o_h_err, o_v_err
   );

   modport slave (
      input  i_hs, i_vs, i_rgb,
      output o_x, o_y, o_active, o_pixel, o_frame_start,
      output o_locked, o_h_err, o_v_err
   );
endinterface

// File: rtl/vga_timing_decoder.sv
// ---------------------------------------------------------------------------
// vga_timing_decoder
// Receive-side counterpart of the 640x480 video generator. Samples the
// HSYNC/VSYNC/RGB pins, rebuilds the raster position, checks line and frame
// timing against the parameters and reports lock plus error pulses.
// Ports:
//   clk    pixel clock (same clock as the generator)
//   reset  synchronous, active high
//   vid    vga_timing_decoder_if.slave (pins in, recovered pixel/status out)
// Pipeline: stage 1 registers the pins, stage 2 is the output register, so
// every output is two clocks behind the pins and all outputs stay aligned.
// ---------------------------------------------------------------------------
module vga_timing_decoder #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                clk,
   input  logic                reset,
   vga_timing_decoder_if.slave vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  CNT_MAX     = 10'h3FF;
   localparam logic [9:0]  H_START     = 10'(H_SYNC + H_BP);
   localparam logic [9:0]  H_STOP      = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0]  V_START     = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  V_STOP      = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [10:0] H_TOTAL_W   = 11'(H_TOTAL);
   localparam logic [10:0] V_TOTAL_W   = 11'(V_TOTAL);
   localparam logic [9:0]  H_SYNC_LAST = 10'(H_SYNC - 1);
   localparam logic [9:0]  V_SYNC_LAST = 10'(V_SYNC - 1);
   localparam logic [3:0]  LOCK_TARGET = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LINE,
      ST_FRAME,
      ST_LOCKED
   } state_t;

   // stage 1: pin samples and edge history
   logic       hs_r_q,    hs_r_d;
   logic       vs_r_q,    vs_r_d;
   logic       rgb_r_q,   rgb_r_d;
   logic       hs_prev_q, hs_prev_d;
   logic       vs_line_q, vs_line_d;
   logic [9:0] hcnt_q,    hcnt_d;
   logic [9:0] vcnt_q,    vcnt_d;
   state_t     state_q,   state_d;
   logic [3:0] good_q,    good_d;

   // stage 2: output register
   logic [9:0] x_q,           x_d;
   logic [9:0] y_q,           y_d;
   logic       active_q,      active_d;
   logic       pixel_q,       pixel_d;
   logic       frame_start_q, frame_start_d;
   logic       locked_q,      locked_d;
   logic       h_err_q,       h_err_d;
   logic       v_err_q,       v_err_d;

   logic hs_fall, hs_rise, vs_start, vs_end;
   logic checking, h_err, v_err, sync_lost;
   logic h_vis, v_vis;

   always_comb begin
      hs_r_d    = vid.i_hs;
      vs_r_d    = vid.i_vs;
      rgb_r_d   = vid.i_rgb;
      hs_prev_d = hs_r_q;

      hs_fall  = hs_prev_q & ~hs_r_q;
      hs_rise  = ~hs_prev_q & hs_r_q;
      // VSYNC is only looked at on line starts; its edges are judged there
      vs_start = hs_fall & vs_line_q & ~vs_r_q;
      vs_end   = hs_fall & ~vs_line_q & vs_r_q;

      vs_line_d = hs_fall ? vs_r_q : vs_line_q;

      // hcnt_d/vcnt_d are the coordinates of the sample now in stage 1
      if (hs_fall) begin
         hcnt_d = '0;
      end else if (hcnt_q == CNT_MAX) begin
         hcnt_d = CNT_MAX;
      end else begin
         hcnt_d = hcnt_q + 10'd1;
      end

      if (!hs_fall) begin
         vcnt_d = vcnt_q;
      end else if (vs_start) begin
         vcnt_d = '0;
      end else if (vcnt_q == CNT_MAX) begin
         vcnt_d = CNT_MAX;
      end else begin
         vcnt_d = vcnt_q + 10'd1;
      end

      // hcnt_q/vcnt_q still hold the last sample of the previous line/frame
      checking = (state_q != ST_IDLE);
      h_err    = checking &&
                 ((hs_fall && (({1'b0, hcnt_q} + 11'd1) != H_TOTAL_W)) ||
                  (hs_rise && (hcnt_q != H_SYNC_LAST)));
      // the first vsync seen in LINE closes a frame of unknown length
      v_err    = checking &&
                 ((vs_start && (state_q != ST_LINE) &&
                   (({1'b0, vcnt_q} + 11'd1) != V_TOTAL_W)) ||
                  (vs_end && (vcnt_q != V_SYNC_LAST)));

      sync_lost = (hcnt_d == CNT_MAX) || (vcnt_d == CNT_MAX);

      state_d = state_q;
      good_d  = good_q;
      if (sync_lost) begin
         state_d = ST_IDLE;
         good_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (hs_fall) begin
                  state_d = ST_LINE;
                  good_d  = '0;
               end
            end
            ST_LINE: begin
               if (vs_start && !h_err && !v_err) begin
                  state_d = ST_FRAME;
                  good_d  = '0;
               end
            end
            ST_FRAME: begin
               if (h_err || v_err) begin
                  state_d = ST_LINE;
                  good_d  = '0;
               end else if (vs_start) begin
                  good_d = good_q + 4'd1;
                  if ((good_q + 4'd1) == LOCK_TARGET) begin
                     state_d = ST_LOCKED;
                  end
               end
            end
            ST_LOCKED: begin
               if (h_err || v_err) begin
                  state_d = ST_LINE;
                  good_d  = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               good_d  = '0;
            end
         endcase
      end

      h_vis = (hcnt_d >= H_START) && (hcnt_d < H_STOP);
      v_vis = (vcnt_d >= V_START) && (vcnt_d < V_STOP);

      active_d      = (state_q == ST_LOCKED) && h_vis && v_vis;
      x_d           = active_d ? (hcnt_d - H_START) : '0;
      y_d           = active_d ? (vcnt_d - V_START) : '0;
      pixel_d       = active_d & rgb_r_q;
      frame_start_d = active_d && (hcnt_d == H_START) && (vcnt_d == V_START);
      // follows the state one cycle behind, so lock drops the cycle after an error pulse
      locked_d      = (state_q == ST_LOCKED);
      h_err_d       = h_err;
      v_err_d       = v_err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // sync registers rest at the idle (high) level so release makes no edge
         hs_r_q        <= 1'b1;
         vs_r_q        <= 1'b1;
         rgb_r_q       <= 1'b0;
         hs_prev_q     <= 1'b1;
         vs_line_q     <= 1'b1;
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         state_q       <= ST_IDLE;
         good_q        <= '0;
         x_q           <= '0;
         y_q           <= '0;
         active_q      <= 1'b0;
         pixel_q       <= 1'b0;
         frame_start_q <= 1'b0;
         locked_q      <= 1'b0;
         h_err_q       <= 1'b0;
         v_err_q       <= 1'b0;
      end else begin
         hs_r_q        <= hs_r_d;
         vs_r_q        <= vs_r_d;
         rgb_r_q       <= rgb_r_d;
         hs_prev_q     <= hs_prev_d;
         vs_line_q     <= vs_line_d;
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         state_q       <= state_d;
         good_q        <= good_d;
         x_q           <= x_d;
         y_q           <= y_d;
         active_q      <= active_d;
         pixel_q       <= pixel_d;
         frame_start_q <= frame_start_d;
         locked_q      <= locked_d;
         h_err_q       <= h_err_d;
         v_err_q       <= v_err_d;
      end
   end

   assign vid.o_x           = x_q;
   assign vid.o_y           = y_q;
   assign vid.o_active      = active_q;
   assign vid.o_pixel       = pixel_q;
   assign vid.o_frame_start = frame_start_q;
   assign vid.o_locked      = locked_q;
   assign vid.o_h_err       = h_err_q;
   assign vid.o_v_err       = v_err_q;

endmodule

// File: tb/tb_vga_timing_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_decoder
// Drives a scaled-down raster (32 clocks/line, 13 lines/frame) into the
// decoder. Every visible pixel the decoder is expected to report is pushed
// into a scoreboard queue by the driver; a monitor on the falling clock edge
// pops and compares whenever o_active is high. Lock state and error pulse
// counts are checked at the end of each scenario.
// ---------------------------------------------------------------------------
module tb_vga_timing_decoder;
   localparam int HA = 16, HF = 4, HS = 8, HB = 4;
   localparam int HT = HA + HF + HS + HB;
   localparam int HSTART = HS + HB;
   localparam int VA = 6, VF = 2, VS = 2, VB = 3;
   localparam int VT = VA + VF + VS + VB;
   localparam int VSTART = VS + VB;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       pix;
      logic       fs;
   } pix_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   h_err_seen = 0;
   int   v_err_seen = 0;
   int   fs_seen = 0;
   pix_t sb[$];

   vga_timing_decoder_if vif();

   vga_timing_decoder #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .LOCK_FRAMES(2)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .vid  (vif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end else begin
         $display("[TB] %s = %0d ok", name, act);
      end
   endtask

   task automatic tick(input logic hs, input logic vs, input logic rgb, input logic rst);
      vif.i_hs  = hs;
      vif.i_vs  = vs;
      vif.i_rgb = rgb;
      reset     = rst;
      @(posedge clk);
      #1;
   endtask

   // One frame of pins. lock_until: lines below it are expected visible on the
   // outputs; rst_line/rst_col place a one-cycle reset pulse (pixels from
   // rst_col-1 on that line are swallowed by the pipeline).
   task automatic drive_frame(input int nlines, input int vsw, input int short_line,
                              input int hsw_line, input int lock_until,
                              input int rst_line, input int rst_col);
      for (int l = 0; l < nlines; l++) begin
         int len;
         int hsw;
         len = (l == short_line) ? HT - 1 : HT;
         hsw = (l == hsw_line) ? HS - 1 : HS;
         for (int c = 0; c < len; c++) begin
            int   x;
            int   y;
            logic vis;
            logic p;
            logic rst;
            pix_t e;
            x   = c - HSTART;
            y   = l - VSTART;
            vis = (c >= HSTART) && (c < HSTART + HA) && (l >= VSTART) && (l < VSTART + VA);
            p   = vis ? (x[0] ^ y[0]) : 1'b0;
            rst = (l == rst_line) && (c == rst_col);
            if (vis && ((l < lock_until) || ((l == rst_line) && (c < rst_col - 1)))) begin
               e.x  = 10'(x);
               e.y  = 10'(y);
               e.pix = p;
               e.fs = (x == 0) && (y == 0);
               sb.push_back(e);
            end
            tick(!(c < hsw), !(l < vsw), p, rst);
            if (rst) begin
               check("midreset_o_x", int'(vif.o_x), 0);
               check("midreset_o_active", int'(vif.o_active), 0);
               check("midreset_o_locked", int'(vif.o_locked), 0);
               check("midreset_o_y", int'(vif.o_y), 0);
            end
         end
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      pix_t e;
      if (vif.o_h_err) h_err_seen++;
      if (vif.o_v_err) v_err_seen++;
      if (vif.o_frame_start) fs_seen++;
      tests++;
      if (vif.o_active) begin
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL pixel_unexpected: got active at (%0d,%0d), required inactive",
                     vif.o_x, vif.o_y);
         end else begin
            e = sb.pop_front();
            if ({vif.o_x, vif.o_y, vif.o_pixel, vif.o_frame_start} !== {e.x, e.y, e.pix, e.fs}) begin
               fails++;
               $display("FAIL pixel: got (%0d,%0d) pix=%0d fs=%0d, required (%0d,%0d) pix=%0d fs=%0d",
                        vif.o_x, vif.o_y, vif.o_pixel, vif.o_frame_start, e.x, e.y, e.pix, e.fs);
            end else begin
               $display("[TB] pixel (%0d,%0d) pix=%0d fs=%0d ok", e.x, e.y, e.pix, e.fs);
            end
         end
      end else if ((vif.o_x !== 10'd0) || (vif.o_y !== 10'd0) ||
                   (vif.o_pixel !== 1'b0) || (vif.o_frame_start !== 1'b0)) begin
         fails++;
         $display("FAIL idle_outputs: got x=%0d y=%0d pix=%0d fs=%0d, required all 0",
                  vif.o_x, vif.o_y, vif.o_pixel, vif.o_frame_start);
      end
   end

   initial begin
      // reset
      repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b1);
      check("reset_o_locked", int'(vif.o_locked), 0);
      check("reset_o_active", int'(vif.o_active), 0);
      check("reset_o_x", int'(vif.o_x), 0);
      check("reset_o_h_err", int'(vif.o_h_err), 0);
      check("reset_o_v_err", int'(vif.o_v_err), 0);

      // initial acquisition: F0 in LINE, F1/F2 counted, F3 locked
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      check("acq_locked_before", int'(vif.o_locked), 0);
      drive_frame(VT, VS, -1, -1, VT, -1, -1);
      check("acq_locked", int'(vif.o_locked), 1);
      check("acq_h_err", h_err_seen, 0);
      check("acq_v_err", v_err_seen, 0);

      // one short line (line 7) while locked
      drive_frame(VT, VS, 7, -1, 8, -1, -1);
      check("short_line_h_err", h_err_seen, 1);
      check("short_line_locked", int'(vif.o_locked), 0);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      check("short_line_relock_early", int'(vif.o_locked), 0);
      drive_frame(VT, VS, -1, -1, VT, -1, -1);
      check("short_line_relock", int'(vif.o_locked), 1);
      check("short_line_v_err", v_err_seen, 0);

      // HSYNC one clock narrow on line 3
      drive_frame(VT, VS, -1, 3, 3, -1, -1);
      check("hsync_narrow_h_err", h_err_seen, 2);
      check("hsync_narrow_locked", int'(vif.o_locked), 0);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, VT, -1, -1);
      check("hsync_narrow_relock", int'(vif.o_locked), 1);

      // frame one line short; error shows at the next vsync start
      drive_frame(VT - 1, VS, -1, -1, VT, -1, -1);
      check("short_frame_v_err_pending", v_err_seen, 0);
      check("short_frame_locked_pending", int'(vif.o_locked), 1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      check("short_frame_v_err", v_err_seen, 1);
      check("short_frame_locked", int'(vif.o_locked), 0);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, VT, -1, -1);
      check("short_frame_relock", int'(vif.o_locked), 1);

      // VSYNC three lines wide
      drive_frame(VT, VS + 1, -1, -1, 3, -1, -1);
      check("vsync_wide_v_err", v_err_seen, 2);
      check("vsync_wide_locked", int'(vif.o_locked), 0);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, VT, -1, -1);
      check("vsync_wide_relock", int'(vif.o_locked), 1);
      check("vsync_wide_h_err", h_err_seen, 2);

      // sync lost: HSYNC held high long enough to saturate the counter
      repeat (1100) tick(1'b1, 1'b1, 1'b0, 1'b0);
      check("sync_lost_locked", int'(vif.o_locked), 0);
      check("sync_lost_h_err", h_err_seen, 2);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      check("sync_lost_relock_early", int'(vif.o_locked), 0);

      // relocked frame with a one-cycle reset at line 7 col 20
      drive_frame(VT, VS, -1, -1, 7, 7, 20);
      check("midreset_locked_after", int'(vif.o_locked), 0);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      drive_frame(VT, VS, -1, -1, 0, -1, -1);
      check("midreset_relock_early", int'(vif.o_locked), 0);
      drive_frame(VT, VS, -1, -1, VT, -1, -1);
      check("midreset_relock", int'(vif.o_locked), 1);

      repeat (4) tick(1'b1, 1'b1, 1'b0, 1'b0);
      check("final_h_err", h_err_seen, 2);
      check("final_v_err", v_err_seen, 2);
      check("frame_start_count", fs_seen, 9);
      check("scoreboard_left", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
